vram_painter: RTL



---
 rtl/vram_painter_pkg.sv | 23 ++
 rtl/vram_painter_if.sv | 33 +++
 rtl/vram_painter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vram_painter_pkg.sv
// Shared types and defaults for the framebuffer write stage.
// Holds the FSM encoding and the pixel-to-address mapping.
package vram_pkg;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_PAINT
  } state_t;

  localparam int VRAM_W_DEF = 240;
  localparam int VRAM_H_DEF = 320;
  localparam int W_DEF      = 8;

  function automatic int xy_to_addr(
    input int x,
    input int y,
    input int w
  );
    return y * w + x;
  endfunction

endpackage

// File: rtl/vram_painter_if.sv
// Touch event valid/ready channel into the painter.
// master drives the touch, slave accepts it.
interface vram_painter_if
  import vram_pkg::*;
#(
  parameter int XW = $clog2(VRAM_W_DEF),
  parameter int YW = $clog2(VRAM_H_DEF),
  parameter int W  = W_DEF
) ();

  logic          touch_valid;
  logic          touch_ready;
  logic [XW-1:0] touch_x;
  logic [YW-1:0] touch_y;
  logic [W-1:0]  touch_color;

  modport master (
    output touch_valid,
    output touch_x,
    output touch_y,
    output touch_color,
    input  touch_ready
  );

  modport slave (
    input  touch_valid,
    input  touch_x,
    input  touch_y,
    input  touch_color,
    output touch_ready
  );

endinterface

// File: rtl/vram_painter.sv
// Framebuffer write stage: full clear after reset or on request,
// then a clipped square brush stamped around each accepted touch.
module vram_painter
  import vram_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int VRAM_W = VRAM_W_DEF,
  parameter int VRAM_H = VRAM_H_DEF,
  parameter int L = VRAM_W * VRAM_H,
  parameter int BRUSH_R = 1,
  parameter logic [W-1:0] CLEAR_COLOR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  vram_painter_if.slave        tch,
  input  logic                 clear_req,
  output logic                 busy,
  output logic                 wr_ena,
  output logic [$clog2(L)-1:0] wr_addr,
  output logic [W-1:0]         wr_data
);

  localparam int AW = $clog2(L);
  localparam int XW = $clog2(VRAM_W);
  localparam int YW = $clog2(VRAM_H);
  localparam int DW = $clog2(2 * BRUSH_R + 1) + 2;

  localparam logic [AW-1:0] LAST = AW'(L - 1);
  localparam logic signed [DW-1:0] RMIN = DW'(-BRUSH_R);
  localparam logic signed [DW-1:0] RMAX = DW'(BRUSH_R);

  state_t state, state_n;

  logic [AW-1:0] cnt, cnt_n;
  logic [XW-1:0] lx, lx_n;
  logic [YW-1:0] ly, ly_n;
  logic [W-1:0]  lc, lc_n;
  logic signed [DW-1:0] dx, dx_n;
  logic signed [DW-1:0] dy, dy_n;
  logic pend, pend_n;

  logic          ena_n;
  logic [AW-1:0] addr_n;
  logic [W-1:0]  data_n;
  logic          ready_n;
  logic          busy_n;

  int   px, py;
  logic in_rng;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lx_n    = lx;
    ly_n    = ly;
    lc_n    = lc;
    dx_n    = dx;
    dy_n    = dy;
    pend_n  = pend;
    ena_n   = 1'b0;
    addr_n  = wr_addr;
    data_n  = wr_data;

    // int math keeps negative offsets and past-edge sums honest
    px = int'(lx) + int'(dx);
    py = int'(ly) + int'(dy);
    in_rng = (px >= 0) && (px < VRAM_W)
          && (py >= 0) && (py < VRAM_H);

    unique case (state)
      S_CLEAR: begin
        ena_n  = 1'b1;
        addr_n = cnt;
        data_n = CLEAR_COLOR;
        cnt_n  = cnt + AW'(1);
        if (cnt == LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      S_IDLE: begin
        if (clear_req || pend) begin
          state_n = S_CLEAR;
          cnt_n   = '0;
          pend_n  = 1'b0;
        end else if (tch.touch_valid && tch.touch_ready) begin
          lx_n    = tch.touch_x;
          ly_n    = tch.touch_y;
          lc_n    = tch.touch_color;
          dx_n    = RMIN;
          dy_n    = RMIN;
          state_n = S_PAINT;
        end
      end
      S_PAINT: begin
        if (clear_req) pend_n = 1'b1;
        ena_n = in_rng;
        if (in_rng) begin
          addr_n = AW'(xy_to_addr(px, py, VRAM_W));
          data_n = lc;
        end
        if (dx == RMAX) begin
          dx_n = RMIN;
          dy_n = dy + DW'(1);
          if (dy == RMAX) begin
            state_n = (pend || clear_req) ? S_CLEAR : S_IDLE;
            pend_n  = 1'b0;
            cnt_n   = '0;
          end
        end else begin
          dx_n = dx + DW'(1);
        end
      end
      default: state_n = S_CLEAR;
    endcase

    ready_n = (state == S_IDLE) && (state_n == S_IDLE);
    busy_n  = !ready_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_CLEAR;
      cnt             <= '0;
      lx              <= '0;
      ly              <= '0;
      lc              <= '0;
      dx              <= RMIN;
      dy              <= RMIN;
      pend            <= 1'b0;
      wr_ena          <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      tch.touch_ready <= 1'b0;
      busy            <= 1'b1;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      lx              <= lx_n;
      ly              <= ly_n;
      lc              <= lc_n;
      dx              <= dx_n;
      dy              <= dy_n;
      pend            <= pend_n;
      wr_ena          <= ena_n;
      wr_addr         <= addr_n;
      wr_data         <= data_n;
      tch.touch_ready <= ready_n;
      busy            <= busy_n;
    end
  end

endmodule
